// File: rtl/soc_system_busy_cond.sv
// Busy-line conditioner: 2-flop sync, FILTER_LEN glitch filter, edge pulses, interval length, sticky timeout.
// busy_out lags busy_raw by FILTER_LEN+1 edges; no backpressure. Timeout logic under SOC_SYSTEM_BUSY_COND_TIMEOUT_EN.
module soc_system_busy_cond #(
  parameter int FILTER_LEN = 4,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             busy_raw,
  input  logic             clr_timeout,
  output logic             busy_out,
  output logic             busy_rise,
  output logic             busy_fall,
  output logic [CNT_W-1:0] busy_len,
  output logic             len_valid,
  output logic             timeout
);

  localparam logic [7:0]       FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] LEN_MAX   = '1;
  localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT);

  logic             sync1;
  logic             sync2;
  logic [7:0]       filt_cnt;
  logic [CNT_W-1:0] len_cnt;
  logic             mismatch;
  logic             flip;
  logic             busy_nxt;
  logic [CNT_W-1:0] len_nxt;

  always_comb begin
    mismatch = sync2 ^ busy_out;
    flip     = mismatch && (filt_cnt == FILT_LAST);
    busy_nxt = busy_out ^ flip;
    len_nxt  = '0;
    if (flip && !busy_out) begin
      len_nxt = CNT_W'(1);
    end else if (busy_out && !flip) begin
      // saturate rather than wrap so long intervals read as the max value
      len_nxt = (len_cnt == LEN_MAX) ? len_cnt : len_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      filt_cnt  <= 8'd0;
      busy_out  <= 1'b0;
      busy_rise <= 1'b0;
      busy_fall <= 1'b0;
      len_cnt   <= '0;
      busy_len  <= '0;
      len_valid <= 1'b0;
    end else begin
      sync1     <= busy_raw;
      sync2     <= sync1;
      filt_cnt  <= (mismatch && !flip) ? filt_cnt + 8'd1 : 8'd0;
      busy_out  <= busy_nxt;
      busy_rise <= flip && !busy_out;
      busy_fall <= flip && busy_out;
      len_cnt   <= len_nxt;
      len_valid <= flip && busy_out;
      if (flip && busy_out) begin
        busy_len <= len_cnt;
      end
    end
  end

`ifdef SOC_SYSTEM_BUSY_COND_TIMEOUT_EN
  logic to_set;

  // fire only on the edge the count arrives at TIMEOUT, so a count parked there by saturation can still be cleared
  assign to_set = busy_nxt && (len_nxt == TO_VAL) && (len_cnt != TO_VAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if (to_set) begin
      timeout <= 1'b1;
    end else if (clr_timeout) begin
      timeout <= 1'b0;
    end
  end
`else
  logic             unused_clr;
  logic [CNT_W-1:0] unused_to;

  assign unused_clr = clr_timeout;
  assign unused_to  = TO_VAL;
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_soc_system_busy_cond.sv
// Scoreboard bench: expected busy_len values are queued when a busy pulse is driven and popped on len_valid.
module tb_soc_system_busy_cond;

`ifdef SOC_SYSTEM_BUSY_COND_TIMEOUT_EN
  localparam logic TO_EXP = 1'b1;
`else
  localparam logic TO_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        busy_raw;
  logic        clr_timeout;
  logic        busy_out, busy_rise, busy_fall, len_valid, timeout;
  logic [15:0] busy_len;
  logic        s_out, s_rise, s_fall, s_lv, s_to;
  logic [3:0]  s_len;

  int          checks = 0;
  int          errors = 0;
  int          rise_cnt = 0;
  logic        any_high = 1'b0;
  logic [31:0] q[$];
  logic [31:0] q_sat[$];

  always #5 clk = ~clk;

  soc_system_busy_cond #(.FILTER_LEN(4), .CNT_W(16), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .busy_raw(busy_raw), .clr_timeout(clr_timeout),
    .busy_out(busy_out), .busy_rise(busy_rise), .busy_fall(busy_fall),
    .busy_len(busy_len), .len_valid(len_valid), .timeout(timeout)
  );

  soc_system_busy_cond #(.FILTER_LEN(4), .CNT_W(4), .TIMEOUT(12)) dut_sat (
    .clk(clk), .reset(reset), .busy_raw(busy_raw), .clr_timeout(clr_timeout),
    .busy_out(s_out), .busy_rise(s_rise), .busy_fall(s_fall),
    .busy_len(s_len), .len_valid(s_lv), .timeout(s_to)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy_rise) rise_cnt++;
    if (busy_out) any_high = 1'b1;
    if (busy_rise && busy_fall) check("rise_fall_both", 1, 0);
    if (busy_fall || len_valid) check("fall_lv", 32'(len_valid), 32'(busy_fall));
    if (len_valid) begin
      if (q.size() == 0) check("len_unexp", 1, 0);
      else check("len", 32'(busy_len), q.pop_front());
    end
    if (s_lv) begin
      if (q_sat.size() == 0) check("len_sat_unexp", 1, 0);
      else check("len_sat", 32'(s_len), q_sat.pop_front());
    end
  end

  task automatic busy_pulse(input int n, input int exp_len, input int exp_sat);
    busy_raw = 1'b1;
    if (exp_len > 0) begin
      q.push_back(32'(exp_len));
      q_sat.push_back(32'(exp_sat));
    end
    repeat (n) @(negedge clk);
    busy_raw = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic clear_timeout();
    clr_timeout = 1'b1;
    @(negedge clk);
    clr_timeout = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    busy_raw = 1'b0;
    clr_timeout = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'(busy_out), 0);
    check("rst_rise", 32'(busy_rise), 0);
    check("rst_fall", 32'(busy_fall), 0);
    check("rst_lv", 32'(len_valid), 0);
    check("rst_len", 32'(busy_len), 0);
    check("rst_to", 32'(timeout), 0);
    reset = 1'b0;
    @(negedge clk);

    // 50-cycle interval: latency, single rise pulse, timeout threshold
    busy_raw = 1'b1;
    q.push_back(50);
    q_sat.push_back(15);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 5) check("lat_pre", 32'(busy_out), 0);
      if (c == 6) begin
        check("lat_out", 32'(busy_out), 1);
        check("lat_rise", 32'(busy_rise), 1);
      end
      if (c == 7) check("rise_once", 32'(busy_rise), 0);
      if (c == 24) check("to_pre", 32'(timeout), 0);
      if (c == 26) check("to_set", 32'(timeout), 32'(TO_EXP));
    end
    busy_raw = 1'b0;
    repeat (10) @(negedge clk);
    check("fall_out", 32'(busy_out), 0);
    check("to_sticky", 32'(timeout), 32'(TO_EXP));
    clear_timeout();
    check("to_clr", 32'(timeout), 0);

    // 3-cycle glitch must be filtered out
    any_high = 1'b0;
    busy_pulse(3, 0, 0);
    check("glitch_out", 32'(any_high), 0);
    check("glitch_rises", 32'(rise_cnt), 1);

    // exactly FILTER_LEN cycles passes
    busy_pulse(4, 4, 4);
    check("min_rises", 32'(rise_cnt), 2);

    // 40 cycles: saturates the 4-bit instance at 15
    busy_pulse(40, 40, 15);
    check("to_40", 32'(timeout), 32'(TO_EXP));
    clear_timeout();
    check("to_clr2", 32'(timeout), 0);

    // reset at busy_out high cycle 7
    busy_raw = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_high", 32'(busy_out), 1);
    reset = 1'b1;
    clr_timeout = 1'b1;
    @(negedge clk);
    check("mid_out", 32'(busy_out), 0);
    check("mid_fall", 32'(busy_fall), 0);
    check("mid_lv", 32'(len_valid), 0);
    check("mid_len_not_loaded", 32'(busy_len == 16'd7), 0);
    check("mid_to", 32'(timeout), 0);
    busy_raw = 1'b0;
    clr_timeout = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_out", 32'(busy_out), 0);

    check("q_empty", 32'(q.size()), 0);
    check("q_sat_empty", 32'(q_sat.size()), 0);
    check("rises", 32'(rise_cnt), 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_system_busy_cond.md
SOC_SYSTEM_BUSY_COND -- requirements
Module: soc_system_busy_cond

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 4, meaning consecutive mismatching synchronized samples required to change busy_out (legal 1..255).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the busy-interval length counter.
REQ-003 The block SHALL have parameter TIMEOUT, default 1000, meaning busy_out-high cycle count that sets timeout (legal 1..2^CNT_W-1).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-006 The block SHALL have port busy_raw, input, 1, asynchronous external busy line.
REQ-007 The block SHALL have port busy_out, output, 1, filtered busy level driving the busy PIO in_port.
REQ-008 The block SHALL have ports busy_rise and busy_fall, output, 1 each, single-cycle pulses on busy_out 0->1 and 1->0.
REQ-009 The block SHALL have port busy_len, output, CNT_W, length in cycles of the last completed busy interval.
REQ-010 The block SHALL have port len_valid, output, 1, single-cycle pulse when busy_len updates.
REQ-011 The block SHALL have ports timeout (output, 1, sticky flag) and clr_timeout (input, 1, clear request).

Function
REQ-012 busy_raw SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-013 Filter: filt_cnt SHALL increment each cycle sync2 != busy_out and clear each cycle sync2 == busy_out.
REQ-014 When sync2 != busy_out and filt_cnt == FILTER_LEN-1, busy_out SHALL toggle and filt_cnt SHALL clear on that edge.
REQ-015 Latency: a busy_raw change stable before edge k SHALL change busy_out at edge k+FILTER_LEN+1; excursions lasting fewer than FILTER_LEN synchronized cycles SHALL never change busy_out.
REQ-016 busy_rise/busy_fall SHALL be registered and asserted for exactly the one cycle after the edge where busy_out changes, never both at once.
REQ-017 len_cnt SHALL load 1 on the edge busy_out rises, increment each cycle busy_out is high, and saturate at 2^CNT_W-1 (no wrap).
REQ-018 On the edge busy_out falls, busy_len SHALL load len_cnt and len_valid SHALL pulse one cycle; busy_len holds otherwise.
REQ-019 timeout SHALL set on the edge len_cnt reaches TIMEOUT while busy_out is high and stay set until clr_timeout; set wins over a simultaneous clear.
REQ-020 A saturated interval SHALL report busy_len = 2^CNT_W-1.

Reset
REQ-021 reset SHALL force sync1, sync2, busy_out, filt_cnt, len_cnt, busy_len, busy_rise, busy_fall, len_valid and timeout to 0 on the next rising edge.
REQ-022 Reset mid-interval SHALL drop busy_out to 0 with no busy_fall or len_valid pulse and no busy_len update.
REQ-023 Reset SHALL take priority over every other input, including clr_timeout.

Configuration
REQ-024 Macro SOC_SYSTEM_BUSY_COND_TIMEOUT_EN: when defined, the timeout logic of REQ-019 SHALL be compiled in.
REQ-025 When SOC_SYSTEM_BUSY_COND_TIMEOUT_EN is undefined, the timeout port SHALL remain present and tie to constant 0, clr_timeout SHALL be ignored, and all other behaviour SHALL be unchanged.

Verification
REQ-026 FILTER_LEN=4: busy_raw 0->1 stable before edge 10 -> busy_out 1 at edge 15, busy_rise high for one cycle only.
REQ-027 FILTER_LEN=4: busy_raw high pulse of 3 cycles -> busy_out, busy_rise, len_valid stay 0.
REQ-028 busy_out high 50 cycles then low -> busy_len=50, len_valid one-cycle pulse with busy_fall.
REQ-029 CNT_W=4, busy high 40 cycles -> len_cnt saturates at 15, busy_len=15 on fall.
REQ-030 TIMEOUT_EN defined, TIMEOUT=20: busy high 25 cycles -> timeout=1 after 20th high cycle, stays 1 after fall; clr_timeout pulse -> 0; macro undefined -> timeout always 0.
REQ-031 reset asserted at busy_out high cycle 7 -> busy_out 0 next edge, no busy_fall, busy_len unchanged, timeout 0.
